// File: rtl/cnn_alu_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cnn_alu_sched
//
// Sequencer for the CNN co-processor ALU (conv / ReLU / pool lanes).
// When a start is accepted it optionally loads the 3x3 filter (conv only). It
// then sweeps the 28x28 image and assembles the window bus (I_out) and filter
// bus (F_out) for the ALU. For every output position it writes the ALU result
// that the latched mode selects to output memory.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, mode       command: one-cycle request, 0=conv 1=ReLU 2=pool 3=rsvd
//   busy, done        status: busy while the job runs, done = one-cycle pulse
//   img_addr/img_re   image memory read port (data valid the next cycle)
//   img_rdata
//   fil_addr/fil_re   filter memory read port (data valid the next cycle)
//   fil_rdata
//   I_out             10-lane window bus, lane k = I_out[k*N +: N]
//   F_out             9-lane filter bus,  lane k = F_out[k*N +: N]
//   c, a, p           ALU conv / ReLU / pool results (combinational from buses)
//   out_addr/out_we   output memory write port
//   out_data
//   perf_cycles       busy-cycle counter, present only with the macro below
//
// Optional feature macro: CNN_ALU_SCHED_PERF_EN
//   Adds perf_cycles. It is cleared on an accepted start and counts every busy
//   cycle. It holds after done and resets to 0 on rst_n.
//
// Filter addresses run 0..8, so F_AW defaults to 4 bits. With 3 bits the
// ninth tap would alias onto address 0.
// -----------------------------------------------------------------------------
module cnn_alu_sched #(
    parameter int N    = 8,
    parameter int M_AW = 10,
    parameter int F_AW = 4,
    parameter int FIL  = 3,
    parameter int IMG  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [M_AW-1:0]   img_addr,
    output logic              img_re,
    input  logic [N-1:0]      img_rdata,
    output logic [F_AW-1:0]   fil_addr,
    output logic              fil_re,
    input  logic [N-1:0]      fil_rdata,
    output logic [10*N-1:0]   I_out,
    output logic [9*N-1:0]    F_out,
    input  logic [N-1:0]      c,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      p,
    output logic [M_AW-1:0]   out_addr,
    output logic              out_we,
    output logic [N-1:0]      out_data
`ifdef CNN_ALU_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int WLANES = 10;
    localparam int FLANES = 9;
    localparam int RC_W   = $clog2(IMG);
    localparam int ST_W   = 4;

    localparam logic [1:0] MODE_CONV = 2'd0;
    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_POOL = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // LOADF issues FTAPS reads and then spends one extra cycle capturing the
    // last word. That gives FTAPS+1 cycles in total.
    localparam logic [ST_W-1:0] FTAPS          = ST_W'(FIL*FIL);
    localparam logic [ST_W-1:0] LAST_STEP_CONV = ST_W'(FIL*FIL-1);
    localparam logic [ST_W-1:0] LAST_STEP_RELU = ST_W'(0);
    localparam logic [ST_W-1:0] LAST_STEP_POOL = ST_W'(3);

    localparam logic [RC_W-1:0] LAST_RC_CONV = RC_W'(IMG-FIL);
    localparam logic [RC_W-1:0] LAST_RC_RELU = RC_W'(IMG-1);
    localparam logic [RC_W-1:0] LAST_RC_POOL = RC_W'(IMG/2-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADF,
        S_FETCH,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [RC_W-1:0]    row_q, row_d;
    logic [RC_W-1:0]    col_q, col_d;
    logic [ST_W-1:0]    step_q, step_d;
    logic [M_AW-1:0]    out_idx_q, out_idx_d;

    // Pending captures: each read issued in one cycle lands in its lane at the
    // end of the following cycle.
    logic               icap_vld_q, icap_vld_d;
    logic [ST_W-1:0]    icap_lane_q, icap_lane_d;
    logic               fcap_vld_q, fcap_vld_d;
    logic [ST_W-1:0]    fcap_lane_q, fcap_lane_d;

    logic [N-1:0]       win_q [WLANES];
    logic [N-1:0]       win_d [WLANES];
    logic [N-1:0]       fil_q [FLANES];
    logic [N-1:0]       fil_d [FLANES];

    logic               start_ok;
    logic [M_AW-1:0]    base;
    logic [ST_W-1:0]    last_step;
    logic [RC_W-1:0]    last_rc;

    // ------------------------------------------------------------------
    // Per-mode geometry helpers
    // ------------------------------------------------------------------

    // Address offset of fetch step s from the position base.
    function automatic logic [M_AW-1:0] fetch_offset(input logic [1:0] m,
                                                     input logic [ST_W-1:0] s);
        logic [M_AW-1:0] off;
        off = '0;
        case (m)
            MODE_CONV: off = M_AW'((int'(s) / FIL) * IMG + int'(s) % FIL);
            MODE_POOL: begin
                case (s)
                    4'd0:    off = M_AW'(0);
                    4'd1:    off = M_AW'(1);
                    4'd2:    off = M_AW'(IMG);
                    default: off = M_AW'(IMG + 1);
                endcase
            end
            default:   off = '0;
        endcase
        return off;
    endfunction

    // Window lane that receives the data of fetch step s. Pool places its
    // bottom-right pixel in lane 9, which is the fourth lane the pool ALU reads.
    function automatic logic [ST_W-1:0] lane_of(input logic [1:0] m,
                                                input logic [ST_W-1:0] s);
        logic [ST_W-1:0] ln;
        ln = '0;
        case (m)
            MODE_CONV: ln = s;
            MODE_POOL: ln = (s == 4'd3) ? 4'd9 : s;
            default:   ln = '0;
        endcase
        return ln;
    endfunction

    always_comb begin
        last_step = LAST_STEP_RELU;
        last_rc   = LAST_RC_RELU;
        base      = M_AW'(row_q) * M_AW'(IMG) + M_AW'(col_q);
        case (mode_q)
            MODE_CONV: begin
                last_step = LAST_STEP_CONV;
                last_rc   = LAST_RC_CONV;
            end
            MODE_POOL: begin
                last_step = LAST_STEP_POOL;
                last_rc   = LAST_RC_POOL;
                // Stride-2 pool: the window origin is (2r, 2c).
                base      = M_AW'(row_q) * M_AW'(2*IMG) + (M_AW'(col_q) << 1);
            end
            default: ;
        endcase
    end

    assign start_ok = start && (mode != MODE_RSVD);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        step_d      = step_q;
        out_idx_d   = out_idx_q;
        win_d       = win_q;
        fil_d       = fil_q;
        icap_vld_d  = 1'b0;
        icap_lane_d = icap_lane_q;
        fcap_vld_d  = 1'b0;
        fcap_lane_d = fcap_lane_q;

        // Land the data of last cycle's reads before the state decides anything.
        if (icap_vld_q) begin
            win_d[icap_lane_q] = img_rdata;
        end
        if (fcap_vld_q) begin
            fil_d[fcap_lane_q] = fil_rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    mode_d    = mode;
                    win_d     = '{default: '0};
                    row_d     = '0;
                    col_d     = '0;
                    step_d    = '0;
                    out_idx_d = '0;
                    state_d   = (mode == MODE_CONV) ? S_LOADF : S_FETCH;
                end
            end

            S_LOADF: begin
                if (step_q != FTAPS) begin
                    fcap_vld_d  = 1'b1;
                    fcap_lane_d = step_q;
                    step_d      = step_q + ST_W'(1);
                end else begin
                    step_d  = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                icap_vld_d  = 1'b1;
                icap_lane_d = lane_of(mode_q, step_q);
                if (step_q == last_step) begin
                    step_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    step_d  = step_q + ST_W'(1);
                end
            end

            S_DRAIN: begin
                state_d = S_WRITE;
            end

            S_WRITE: begin
                out_idx_d = out_idx_q + M_AW'(1);
                if ((row_q == last_rc) && (col_q == last_rc)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    if (col_q == last_rc) begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_CONV;
            row_q       <= '0;
            col_q       <= '0;
            step_q      <= '0;
            out_idx_q   <= '0;
            icap_vld_q  <= 1'b0;
            icap_lane_q <= '0;
            fcap_vld_q  <= 1'b0;
            fcap_lane_q <= '0;
            win_q       <= '{default: '0};
            fil_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            step_q      <= step_d;
            out_idx_q   <= out_idx_d;
            icap_vld_q  <= icap_vld_d;
            icap_lane_q <= icap_lane_d;
            fcap_vld_q  <= fcap_vld_d;
            fcap_lane_q <= fcap_lane_d;
            win_q       <= win_d;
            fil_q       <= fil_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q == S_LOADF) || (state_q == S_FETCH) ||
                   (state_q == S_DRAIN) || (state_q == S_WRITE);
        done     = (state_q == S_DONE);

        img_re   = (state_q == S_FETCH);
        img_addr = img_re ? (base + fetch_offset(mode_q, step_q)) : '0;

        fil_re   = (state_q == S_LOADF) && (step_q != FTAPS);
        fil_addr = fil_re ? F_AW'(step_q) : '0;

        out_we   = (state_q == S_WRITE);
        out_addr = out_we ? out_idx_q : '0;
        out_data = '0;
        if (out_we) begin
            case (mode_q)
                MODE_CONV: out_data = c;
                MODE_RELU: out_data = a;
                default:   out_data = p;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WLANES; gi++) begin : g_win_bus
            assign I_out[gi*N +: N] = win_q[gi];
        end
        for (gi = 0; gi < FLANES; gi++) begin : g_fil_bus
            assign F_out[gi*N +: N] = fil_q[gi];
        end
    endgenerate

`ifdef CNN_ALU_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start_ok) begin
            perf_d = '0;
        end else if (busy) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
